// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 constants, FSM state enum and access decode helpers
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RESP
    } lsu_state_e;

    // Unsupported funct3 encodings are folded into the misaligned error path.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    // Sub-word stores that do not start at lane 0 cannot be written unshifted,
    // so they go through a read-modify-write of the whole word.
    function automatic logic lsu_needs_rmw(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3[1:0])
            2'b00:   return lo != 2'b00;
            2'b01:   return lo == 2'b10;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extract/extend and store lane merge
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      lane_i,
    input  logic [XLEN-1:0] rdata_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_data_o,
    output logic [XLEN-1:0] merge_data_o
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] lane_data;

    assign shamt   = {lane_i, 3'b000};
    assign shifted = rdata_i >> shamt;

    // Pick the addressed byte/half out of the word and extend it per funct3.
    always_comb begin
        load_data_o = rdata_i;
        case (funct3_i)
            F3_B:    load_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_H:    load_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end

    // Overlay the store byte/half onto the word that was just read back.
    always_comb begin
        lane_mask = '0;
        lane_data = '0;
        if (funct3_i[1:0] == 2'b00) begin
            lane_mask = {{(XLEN-8){1'b0}}, 8'hFF} << shamt;
            lane_data = {{(XLEN-8){1'b0}}, wdata_i[7:0]} << shamt;
        end else begin
            lane_mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << shamt;
            lane_data = {{(XLEN-16){1'b0}}, wdata_i[15:0]} << shamt;
        end
        merge_data_o = (rdata_i & ~lane_mask) | lane_data;
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit in front of a word-wide RAM controller
module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int DEPTH     = 4096,
    parameter  int XLEN      = 32,
    localparam int ADDRWIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]      mem_wrData,
    output logic                 mem_wrEn,
    output logic                 mem_rdEn,
    output logic                 mem_byteEn,
    output logic                 mem_halfEn,
    output logic                 mem_wordEn,
    output logic                 mem_unsignedEn,
    input  logic [XLEN-1:0]      mem_dataOut,
    input  logic                 mem_outEn,
    output logic                 rsp_valid,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 rsp_err
);

    lsu_state_e           state_q;
    logic                 store_q;
    logic [2:0]           funct3_q;
    logic [1:0]           lane_q;
    logic [XLEN-1:0]      wdata_q;

    logic [ADDRWIDTH-1:0] mem_addr_q;
    logic [XLEN-1:0]      mem_wrdata_q;
    logic                 mem_wren_q;
    logic                 mem_rden_q;
    logic                 byte_en_q;
    logic                 half_en_q;
    logic                 word_en_q;
    logic                 rsp_valid_q;
    logic [XLEN-1:0]      rsp_data_q;
    logic                 rsp_err_q;

    logic [XLEN-1:0]      load_data_d;
    logic [XLEN-1:0]      merge_data_d;
    logic                 unused_addr;

    // Upper effective-address bits lie outside the RAM and are dropped.
    assign unused_addr = ^req_addr;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .funct3_i    (funct3_q),
        .lane_i      (lane_q),
        .rdata_i     (mem_dataOut),
        .wdata_i     (wdata_q),
        .load_data_o (load_data_d),
        .merge_data_o(merge_data_d)
    );

    // Request sequencing: every memory strobe and response is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wrdata_q <= '0;
            mem_wren_q   <= 1'b0;
            mem_rden_q   <= 1'b0;
            byte_en_q    <= 1'b0;
            half_en_q    <= 1'b0;
            word_en_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            mem_wren_q  <= 1'b0;
            mem_rden_q  <= 1'b0;
            byte_en_q   <= 1'b0;
            half_en_q   <= 1'b0;
            word_en_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        store_q    <= req_store;
                        funct3_q   <= req_funct3;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        mem_addr_q <= req_addr[ADDRWIDTH+1:2];
                        if (lsu_misaligned(req_funct3, req_addr[1:0])) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else if (!req_store || lsu_needs_rmw(req_funct3, req_addr[1:0])) begin
                            state_q    <= RD;
                            mem_rden_q <= 1'b1;
                            word_en_q  <= 1'b1;
                        end else begin
                            state_q      <= WR;
                            mem_wren_q   <= 1'b1;
                            mem_wrdata_q <= req_wdata;
                            byte_en_q    <= (req_funct3[1:0] == 2'b00);
                            half_en_q    <= (req_funct3[1:0] == 2'b01);
                            word_en_q    <= (req_funct3[1:0] == 2'b10);
                        end
                    end
                end
                RD: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_outEn) begin
                        if (store_q) begin
                            state_q      <= WR;
                            mem_wren_q   <= 1'b1;
                            word_en_q    <= 1'b1;
                            mem_wrdata_q <= merge_data_d;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= load_data_d;
                        end
                    end
                end
                WR: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign mem_addr       = mem_addr_q;
    assign mem_wrData     = mem_wrdata_q;
    assign mem_wrEn       = mem_wren_q;
    assign mem_rdEn       = mem_rden_q;
    assign mem_byteEn     = byte_en_q;
    assign mem_halfEn     = half_en_q;
    assign mem_wordEn     = word_en_q;
    assign mem_unsignedEn = 1'b0;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_wrData;
    logic        mem_wrEn;
    logic        mem_rdEn;
    logic        mem_byteEn;
    logic        mem_halfEn;
    logic        mem_wordEn;
    logic        mem_unsignedEn;
    logic [31:0] mem_dataOut;
    logic        mem_outEn;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int tests_run = 0;
    int fails = 0;

    // RAM controller model: read data returns two cycles after mem_rdEn.
    logic        p1 = 1'b0;
    logic        p2 = 1'b0;
    logic [31:0] rd_word = 32'h0;

    always @(posedge clk) begin
        p1 <= mem_rdEn;
        p2 <= p1;
    end
    assign mem_outEn   = p2;
    assign mem_dataOut = p2 ? rd_word : 32'hA5A5A5A5;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .mem_addr      (mem_addr),
        .mem_wrData    (mem_wrData),
        .mem_wrEn      (mem_wrEn),
        .mem_rdEn      (mem_rdEn),
        .mem_byteEn    (mem_byteEn),
        .mem_halfEn    (mem_halfEn),
        .mem_wordEn    (mem_wordEn),
        .mem_unsignedEn(mem_unsignedEn),
        .mem_dataOut   (mem_dataOut),
        .mem_outEn     (mem_outEn),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err)
    );

    // Observations of one transaction, cycle numbers relative to acceptance.
    int          r_rsp, r_rd, r_wr, r_rdn, r_wrn;
    logic [31:0] r_data, r_wdat, r_addr;
    logic        r_err;
    logic [2:0]  r_sz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge with the DUT idle; returns on the following idle cycle.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word);
        rd_word = word;
        r_rsp = -1; r_rd = -1; r_wr = -1; r_rdn = 0; r_wrn = 0;
        r_data = 'x; r_err = 1'bx; r_wdat = 32'h0; r_addr = 32'h0; r_sz = 3'b000;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111;
                req_addr = ~addr; req_wdata = ~wd;
            end
            if (mem_rdEn) begin
                r_rdn++;
                if (r_rd < 0) r_rd = c;
                r_sz = {mem_byteEn, mem_halfEn, mem_wordEn};
                r_addr = {20'h0, mem_addr};
            end
            if (mem_wrEn) begin
                r_wrn++;
                if (r_wr < 0) r_wr = c;
                r_wdat = mem_wrData;
                r_sz = {mem_byteEn, mem_halfEn, mem_wordEn};
                r_addr = {20'h0, mem_addr};
            end
            if (rsp_valid) begin
                r_rsp = c; r_data = rsp_data; r_err = rsp_err;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_strobes", {28'h0, mem_rdEn, mem_wrEn, rsp_valid, rsp_err}, 32'h0);
        chk("reset_addr", {20'h0, mem_addr}, 32'h0);
        chk("reset_wrdata", mem_wrData, 32'h0);
        chk("reset_rspdata", rsp_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x100 -> word 0x40
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF);
        chk("lw_rd_cycle", r_rd, 32'd1);
        chk("lw_rsp_cycle", r_rsp, 32'd4);
        chk("lw_data", r_data, 32'hDEADBEEF);
        chk("lw_err", {31'h0, r_err}, 32'h0);
        chk("lw_addr", r_addr, 32'h40);
        chk("lw_size", {29'h0, r_sz}, 32'h1);
        chk("lw_counts", {r_rdn[15:0], r_wrn[15:0]}, 32'h0001_0000);
        chk("lw_idle_ready", {31'h0, req_ready}, 32'h1);
        chk("lw_rsp_pulse", {31'h0, rsp_valid}, 32'h0);
        chk("unsigned_en", {31'h0, mem_unsignedEn}, 32'h0);

        // Back-to-back: issued in the idle cycle right after the response
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233);
        chk("lb_data", r_data, 32'hFFFFFF80);
        chk("lb_rsp_cycle", r_rsp, 32'd4);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233);
        chk("lbu_data", r_data, 32'h00000080);
        run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233);
        chk("lh_data", r_data, 32'hFFFF8011);
        run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233);
        chk("lhu_data", r_data, 32'h00008011);
        run_op(1'b0, 3'b000, 32'h101, 32'h0, 32'h80112233);
        chk("lb_lane1", r_data, 32'h00000022);

        // SW aligned: direct write
        run_op(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0);
        chk("sw_wr_cycle", r_wr, 32'd1);
        chk("sw_rsp_cycle", r_rsp, 32'd2);
        chk("sw_wdata", r_wdat, 32'hCAFEF00D);
        chk("sw_size", {29'h0, r_sz}, 32'h1);
        chk("sw_addr", r_addr, 32'h80);
        chk("sw_counts", {r_rdn[15:0], r_wrn[15:0]}, 32'h0000_0001);
        chk("sw_rspdata", r_data, 32'h0);

        // SB lane 0: direct byte write, data unshifted
        run_op(1'b1, 3'b000, 32'h24, 32'h12345678, 32'h0);
        chk("sb0_wr_cycle", r_wr, 32'd1);
        chk("sb0_size", {29'h0, r_sz}, 32'h4);
        chk("sb0_wdata", r_wdat, 32'h12345678);
        chk("sb0_rsp_cycle", r_rsp, 32'd2);

        // SH lane 0: direct half write
        run_op(1'b1, 3'b001, 32'h28, 32'h0000BEEF, 32'h0);
        chk("sh0_size", {29'h0, r_sz}, 32'h2);

        // SB 0x21: read-modify-write
        run_op(1'b1, 3'b000, 32'h21, 32'h000000AB, 32'h11223344);
        chk("sb_rd_cycle", r_rd, 32'd1);
        chk("sb_wr_cycle", r_wr, 32'd4);
        chk("sb_wdata", r_wdat, 32'h1122AB44);
        chk("sb_size", {29'h0, r_sz}, 32'h1);
        chk("sb_rsp_cycle", r_rsp, 32'd5);
        chk("sb_addr", r_addr, 32'h8);
        chk("sb_err", {31'h0, r_err}, 32'h0);

        // SH 0x22: read-modify-write of upper half
        run_op(1'b1, 3'b001, 32'h22, 32'h00005566, 32'h11223344);
        chk("sh2_wdata", r_wdat, 32'h55663344);
        chk("sh2_rsp_cycle", r_rsp, 32'd5);

        // Misaligned and unsupported accesses
        run_op(1'b0, 3'b001, 32'h101, 32'h0, 32'h0);
        chk("lh_mis_rsp_cycle", r_rsp, 32'd1);
        chk("lh_mis_err", {31'h0, r_err}, 32'h1);
        chk("lh_mis_counts", {r_rdn[15:0], r_wrn[15:0]}, 32'h0);
        chk("lh_mis_data", r_data, 32'h0);
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h0);
        chk("lw_mis_err", {31'h0, r_err}, 32'h1);
        run_op(1'b1, 3'b010, 32'h201, 32'h0, 32'h0);
        chk("sw_mis_counts", {r_rdn[15:0], r_wrn[15:0], 15'h0, r_err}, 32'h1);
        run_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0);
        chk("f3_011_err", {31'h0, r_err}, 32'h1);

        // Reset during RMW at T2; late mem_outEn lands while idle and is ignored
        rd_word = 32'h11223344;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h21; req_wdata = 32'hAB;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr", {20'h0, mem_addr}, 32'h0);
        chk("async_rst_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (mem_wrEn || rsp_valid) cnt++;
            @(negedge clk);
        end
        chk("rst_abort_activity", cnt, 32'd0);
        chk("rst_abort_ready", {31'h0, req_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
